// File: rtl/ddr_rd_arbiter_2to1.sv
// Two-requester arbiter for a shared 512-bit AXI read master: whole-burst grants,
// one transaction outstanding, read beats steered back to the owner.
//
//   state | meaning
//   IDLE  | no transaction; pick a winner and accept its AR
//   ADDR  | presenting the latched AR on the master port until m_arready
//   DATA  | forwarding R beats to grant_id; closes on the beat count == len_q
module ddr_rd_arbiter_2to1 #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 512,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic [ADDR_W-1:0] s0_araddr,
  input  logic [7:0]        s0_arlen,
  input  logic [2:0]        s0_arsize,
  input  logic [1:0]        s0_arburst,
  input  logic              s0_arvalid,
  output logic              s0_arready,
  output logic [DATA_W-1:0] s0_rdata,
  output logic              s0_rvalid,
  input  logic              s0_rready,

  input  logic [ADDR_W-1:0] s1_araddr,
  input  logic [7:0]        s1_arlen,
  input  logic [2:0]        s1_arsize,
  input  logic [1:0]        s1_arburst,
  input  logic              s1_arvalid,
  output logic              s1_arready,
  output logic [DATA_W-1:0] s1_rdata,
  output logic              s1_rvalid,
  input  logic              s1_rready,

  output logic [ADDR_W-1:0] m_araddr,
  output logic [7:0]        m_arlen,
  output logic [2:0]        m_arsize,
  output logic [1:0]        m_arburst,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_rvalid,
  output logic              m_rready,

  output logic              busy,
  output logic              grant_id,
  output logic              stray_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] m_araddr_q, m_araddr_d;
  logic [7:0]        m_arlen_q, m_arlen_d;
  logic [2:0]        m_arsize_q, m_arsize_d;
  logic [1:0]        m_arburst_q, m_arburst_d;
  logic              m_arvalid_q, m_arvalid_d;
  logic              grant_id_q, grant_id_d;
  logic              stray_err_q, stray_err_d;
  logic              last_q, last_d;
  logic [7:0]        len_q, len_d;
  logic [7:0]        beat_cnt_q, beat_cnt_d;

  logic in_idle;
  logic in_data;
  logic win_id;
  logic ar_fire;
  logic beat_fire;
  logic final_beat;

  assign in_idle = (state_q == IDLE);
  assign in_data = (state_q == DATA);

  // Contention goes to slot 0 in fixed mode, otherwise to whoever did not own the last burst.
  always_comb begin
    win_id = s1_arvalid;
    if (s0_arvalid && s1_arvalid) begin
      win_id = FIXED_PRIO ? 1'b0 : ~last_q;
    end
  end

  assign s0_arready = in_idle & s0_arvalid & ~win_id;
  assign s1_arready = in_idle & s1_arvalid &  win_id;
  assign ar_fire    = s0_arready | s1_arready;

  assign s0_rdata  = m_rdata;
  assign s1_rdata  = m_rdata;
  assign s0_rvalid = in_data & m_rvalid & ~grant_id_q;
  assign s1_rvalid = in_data & m_rvalid &  grant_id_q;
  assign m_rready  = in_data & (grant_id_q ? s1_rready : s0_rready);

  assign beat_fire  = m_rvalid & m_rready;
  assign final_beat = beat_fire & (beat_cnt_q == len_q);

  always_comb begin
    state_d     = state_q;
    m_araddr_d  = m_araddr_q;
    m_arlen_d   = m_arlen_q;
    m_arsize_d  = m_arsize_q;
    m_arburst_d = m_arburst_q;
    m_arvalid_d = m_arvalid_q;
    grant_id_d  = grant_id_q;
    last_d      = last_q;
    len_d       = len_q;
    beat_cnt_d  = beat_cnt_q;
    // Any beat outside DATA has no owner; it is dropped and flagged until reset.
    stray_err_d = stray_err_q | (m_rvalid & ~in_data);

    unique case (state_q)
      IDLE: begin
        if (ar_fire) begin
          m_araddr_d  = win_id ? s1_araddr  : s0_araddr;
          m_arlen_d   = win_id ? s1_arlen   : s0_arlen;
          m_arsize_d  = win_id ? s1_arsize  : s0_arsize;
          m_arburst_d = win_id ? s1_arburst : s0_arburst;
          len_d       = win_id ? s1_arlen   : s0_arlen;
          m_arvalid_d = 1'b1;
          grant_id_d  = win_id;
          beat_cnt_d  = 8'd0;
          state_d     = ADDR;
        end
      end
      ADDR: begin
        if (m_arready) begin
          m_arvalid_d = 1'b0;
          state_d     = DATA;
        end
      end
      DATA: begin
        if (beat_fire) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
          if (final_beat) begin
            last_d  = grant_id_q;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      m_araddr_q  <= '0;
      m_arlen_q   <= 8'd0;
      m_arsize_q  <= 3'd0;
      m_arburst_q <= 2'd0;
      m_arvalid_q <= 1'b0;
      grant_id_q  <= 1'b0;
      stray_err_q <= 1'b0;
      last_q      <= 1'b1;
      len_q       <= 8'd0;
      beat_cnt_q  <= 8'd0;
    end else begin
      state_q     <= state_d;
      m_araddr_q  <= m_araddr_d;
      m_arlen_q   <= m_arlen_d;
      m_arsize_q  <= m_arsize_d;
      m_arburst_q <= m_arburst_d;
      m_arvalid_q <= m_arvalid_d;
      grant_id_q  <= grant_id_d;
      stray_err_q <= stray_err_d;
      last_q      <= last_d;
      len_q       <= len_d;
      beat_cnt_q  <= beat_cnt_d;
    end
  end

  assign m_araddr  = m_araddr_q;
  assign m_arlen   = m_arlen_q;
  assign m_arsize  = m_arsize_q;
  assign m_arburst = m_arburst_q;
  assign m_arvalid = m_arvalid_q;
  assign grant_id  = grant_id_q;
  assign stray_err = stray_err_q;
  assign busy      = ~in_idle;

endmodule
